// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: drives a word-organised RAM bus with a ready
// handshake, aligns sub-word lanes, extends loads and stalls the pipeline meanwhile.
module mem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read_flag,
    input  logic                  mem_write_flag,
    input  logic                  mem_sign_flag,
    input  logic [3:0]            mem_sel,
    input  logic [DATA_WIDTH-1:0] mem_write_data,
    input  logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  ram_en,
    output logic [3:0]            ram_write_en,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_write_data,
    input  logic                  ram_ready,
    input  logic [DATA_WIDTH-1:0] ram_read_data,
    output logic [DATA_WIDTH-1:0] load_data,
    output logic                  load_valid,
    output logic                  stall_request,
    output logic                  misaligned_error,
    output logic                  bus_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t                state_q, state_d;
    logic                  ram_en_q, ram_en_d;
    logic [3:0]            ram_write_en_q, ram_write_en_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_write_data_q, ram_write_data_d;
    logic [DATA_WIDTH-1:0] load_data_q, load_data_d;
    logic                  load_valid_q, load_valid_d;
    logic                  misaligned_error_q, misaligned_error_d;
    logic                  bus_error_q, bus_error_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  is_load_q, is_load_d;
    logic                  sign_q, sign_d;
    size_t                 size_q, size_d;
    logic [1:0]            lane_q, lane_d;

    logic sel_byte, sel_half, sel_word, req, aligned, timeout_hit;
    logic [7:0]            lane_byte;
    logic [15:0]           lane_half;
    logic [DATA_WIDTH-1:0] load_ext;

    assign sel_byte    = (mem_sel == 4'b0001);
    assign sel_half    = (mem_sel == 4'b0011);
    assign sel_word    = (mem_sel == 4'b1111);
    assign req         = (mem_read_flag | mem_write_flag) & (sel_byte | sel_half | sel_word);
    assign aligned     = sel_byte | (sel_half & ~mem_addr[0]) | (sel_word & (mem_addr[1:0] == 2'b00));
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q            <= S_IDLE;
            ram_en_q           <= 1'b0;
            ram_write_en_q     <= '0;
            ram_addr_q         <= '0;
            ram_write_data_q   <= '0;
            load_data_q        <= '0;
            load_valid_q       <= 1'b0;
            misaligned_error_q <= 1'b0;
            bus_error_q        <= 1'b0;
            cnt_q              <= '0;
            is_load_q          <= 1'b0;
            sign_q             <= 1'b0;
            size_q             <= SZ_BYTE;
            lane_q             <= '0;
        end else begin
            state_q            <= state_d;
            ram_en_q           <= ram_en_d;
            ram_write_en_q     <= ram_write_en_d;
            ram_addr_q         <= ram_addr_d;
            ram_write_data_q   <= ram_write_data_d;
            load_data_q        <= load_data_d;
            load_valid_q       <= load_valid_d;
            misaligned_error_q <= misaligned_error_d;
            bus_error_q        <= bus_error_d;
            cnt_q              <= cnt_d;
            is_load_q          <= is_load_d;
            sign_q             <= sign_d;
            size_q             <= size_d;
            lane_q             <= lane_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (req && aligned) state_d = S_BUSY;
            S_BUSY:  if (ram_ready || timeout_hit) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lane_byte = ram_read_data[{lane_q, 3'b000} +: 8];
        lane_half = ram_read_data[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_BYTE: load_ext = {{(DATA_WIDTH-8){sign_q & lane_byte[7]}}, lane_byte};
            SZ_HALF: load_ext = {{(DATA_WIDTH-16){sign_q & lane_half[15]}}, lane_half};
            default: load_ext = ram_read_data;
        endcase
    end

    always_comb begin
        ram_en_d           = ram_en_q;
        ram_write_en_d     = ram_write_en_q;
        ram_addr_d         = ram_addr_q;
        ram_write_data_d   = ram_write_data_q;
        load_data_d        = load_data_q;
        load_valid_d       = 1'b0;
        misaligned_error_d = 1'b0;
        bus_error_d        = 1'b0;
        cnt_d              = cnt_q;
        is_load_d          = is_load_q;
        sign_d             = sign_q;
        size_d             = size_q;
        lane_d             = lane_q;
        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (req && aligned) begin
                    // read wins when both flags are set
                    is_load_d  = mem_read_flag;
                    sign_d     = mem_sign_flag;
                    lane_d     = mem_addr[1:0];
                    size_d     = sel_byte ? SZ_BYTE : (sel_half ? SZ_HALF : SZ_WORD);
                    ram_en_d   = 1'b1;
                    ram_addr_d = {mem_addr[ADDR_WIDTH-1:2], 2'b00};
                    if (sel_byte) begin
                        ram_write_data_d = {4{mem_write_data[7:0]}};
                        ram_write_en_d   = 4'b0001 << mem_addr[1:0];
                    end else if (sel_half) begin
                        ram_write_data_d = {2{mem_write_data[15:0]}};
                        ram_write_en_d   = mem_addr[1] ? 4'b1100 : 4'b0011;
                    end else begin
                        ram_write_data_d = mem_write_data;
                        ram_write_en_d   = 4'b1111;
                    end
                    if (mem_read_flag) ram_write_en_d = 4'b0000;
                end else if (req) begin
                    misaligned_error_d = 1'b1;
                end
            end
            S_BUSY: begin
                if (ram_ready) begin
                    ram_en_d       = 1'b0;
                    ram_write_en_d = 4'b0000;
                    cnt_d          = '0;
                    if (is_load_q) begin
                        load_data_d  = load_ext;
                        load_valid_d = 1'b1;
                    end
                end else if (timeout_hit) begin
                    ram_en_d       = 1'b0;
                    ram_write_en_d = 4'b0000;
                    cnt_d          = '0;
                    bus_error_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign ram_en           = ram_en_q;
    assign ram_write_en     = ram_write_en_q;
    assign ram_addr         = ram_addr_q;
    assign ram_write_data   = ram_write_data_q;
    assign load_data        = load_data_q;
    assign load_valid       = load_valid_q;
    assign misaligned_error = misaligned_error_q;
    assign bus_error        = bus_error_q;
    assign stall_request    = ((state_q == S_IDLE) && req && aligned) || (state_q == S_BUSY);

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- MEM-stage load/store responder that consumes the ID-generated memory controls: read/write flags, sign flag, byte-select mask and store data.
- Performs the access on a word-organised data-RAM bus with a ready handshake, so RAM latency is variable.
- Aligns byte/halfword lanes, sign- or zero-extends load results, and stalls the pipeline until the access completes.
- Detects misaligned accesses and bus timeouts.

Parameters:
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, data width; fixed at 32 for the 4-lane select scheme.
- TIMEOUT_CYCLES, 16, maximum BUSY cycles waiting for ram_ready before abort (>=1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- mem_read_flag  in  1  load request.
- mem_write_flag  in  1  store request.
- mem_sign_flag  in  1  sign-extend load result.
- mem_sel  in  4  0001 byte, 0011 halfword, 1111 word; other codes are treated as no access.
- mem_write_data  in  32  store data; the value sits in the low bits.
- mem_addr  in  32  byte address from EX.
- ram_en  out  1  bus request valid.
- ram_write_en  out  4  per-lane write strobes; 0000 means read.
- ram_addr  out  32  word-aligned address, {mem_addr[31:2],2'b00}.
- ram_write_data  out  32  lane-replicated store data.
- ram_ready  in  1  RAM completes the current request this cycle.
- ram_read_data  in  32  read word, valid when ram_ready=1.
- load_data  out  32  extended load result.
- load_valid  out  1  one-cycle pulse with load_data.
- stall_request  out  1  hold IF/ID/EX.
- misaligned_error  out  1  one-cycle pulse.
- bus_error  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: state IDLE; ram_en, ram_write_en, ram_addr, ram_write_data, load_data, load_valid, misaligned_error, bus_error and timeout counter all 0.
- Request: req = (mem_read_flag|mem_write_flag) & mem_sel∈{0001,0011,1111}. If both flags are set, the read wins.
- Alignment:
  - halfword requires addr[0]=0;
  - word requires addr[1:0]=00;
  - byte is always aligned.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - req & aligned: capture the request into registers; ram_en<=1, ram_addr, strobes and data set on the next edge; go to BUSY.
  - req & misaligned: misaligned_error pulses 1 on the next cycle; no bus access; stay IDLE.
  - Otherwise stay IDLE.
- Strobes:
  - byte: 0001<<addr[1:0];
  - half: 0011<<{addr[1],1'b0};
  - word: 1111;
  - load: 0000.
- Store data replication:
  - byte: {4{d[7:0]}};
  - half: {2{d[15:0]}};
  - word: d.
- BUSY:
  - Bus outputs stay stable.
  - Counter increments each cycle ram_ready=0.
  - On ram_ready=1: ram_en<=0, strobes<=0; for a load, load_data <= extended lane and load_valid<=1; go to DONE.
  - If the counter reaches TIMEOUT_CYCLES-1 with ram_ready=0: abort (ram_en<=0), bus_error<=1 for one cycle, go to DONE.
- DONE: go to IDLE after one cycle; pulse outputs clear. Flags are ignored in DONE because the same instruction is still presented and must not reissue.
- Load extraction:
  - byte lane = addr[1:0], half lane = addr[1];
  - sign-extend if sign flag is set, else zero-extend;
  - word passes through.
- stall_request is combinational: (IDLE & req & aligned) | BUSY. It is 0 in DONE so the pipeline advances at the end of DONE.
- Latency: with ram_ready on the first BUSY cycle, stall is asserted for 2 cycles and load_valid appears in DONE.
- ram_ready outside BUSY is ignored.
- Reset mid-BUSY: the bus drops immediately on that edge; there is no completion pulse.

Test Plan:
- Word load at 0x100: ram_ready on the 3rd BUSY cycle with read data 0xDEADBEEF → ram_addr=0x100, ram_write_en=0000, stall high for 4 cycles, load_data=0xDEADBEEF, load_valid pulse.
- LB at 0x203 with read data 0x80FF_1234, sign=1 → load_data=0xFFFFFF80; same access as LBU (sign=0) → 0x00000080.
- SH at 0x102, data 0x0000ABCD → ram_addr=0x100, ram_write_en=1100, ram_write_data=0xABCDABCD, load_valid stays 0.
- LW at 0x101 → misaligned_error pulses, ram_en never asserts, stall_request low.
- Store with ram_ready held 0 → bus_error pulses after exactly 16 BUSY cycles, then FSM returns to IDLE.
- rst asserted in BUSY → next cycle all outputs 0, state IDLE; a fresh SB at 0x7 then yields ram_write_en=1000.
